// File: rtl/kyber_pkg.sv
// Shared Kyber constants, the parse FSM state type and the rejection test
// used by the keccak_parse sampler.
package kyber_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;
    localparam int COEFF_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RUN
    } parse_state_t;

    // A 12-bit candidate is a uniform coefficient only when it lies below the modulus.
    function automatic logic cand_ok(input logic [COEFF_W-1:0] cand, input int q);
        return int'(cand) < q;
    endfunction

endpackage

// File: rtl/parse_bitbuf.sv
// Append/shift bit buffer for the keccak parser. Whole words are appended
// above the leftover bits and 12-bit candidates are taken from the bottom,
// so the bit stream stays little-endian and contiguous across words.
module parse_bitbuf
    import kyber_pkg::*;
#(
    parameter int WORD_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               push,
    input  logic               pop12,
    input  logic [WORD_W-1:0]  data,
    output logic [COEFF_W-1:0] cand,
    output logic               have12,
    output logic [6:0]         bcnt
);

    localparam int BUF_W = WORD_W + COEFF_W;

    logic [BUF_W-1:0] bits;

    // Fill level: number of valid bits held at the bottom of the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt <= '0;
        end else if (clear) begin
            bcnt <= '0;
        end else if (push) begin
            bcnt <= bcnt + 7'(WORD_W);
        end else if (pop12) begin
            bcnt <= bcnt - 7'(COEFF_W);
        end
    end

    // Buffer contents: OR the new word in above the leftover, shift out consumed candidates.
    always_ff @(posedge clk) begin
        if (clear) begin
            bits <= '0;
        end else if (push) begin
            bits <= bits | (BUF_W'(data) << bcnt);
        end else if (pop12) begin
            bits <= bits >> COEFF_W;
        end
    end

    assign cand   = bits[COEFF_W-1:0];
    assign have12 = (bcnt >= 7'(COEFF_W));

endmodule

// File: rtl/keccak_parse.sv
// Rejection-sampling parser: pulls squeezed words from the keccak output
// FIFO one at a time, chops them into 12-bit candidates and emits those
// below Q as polynomial coefficients 0..N_COEFF-1.
// Optional build macro: KECCAK_PARSE_STATS_EN adds rej_cnt / word_cnt outputs.
module keccak_parse
    import kyber_pkg::*;
#(
    parameter int WORD_W  = 64,
    parameter int N_COEFF = KYBER_N,
    parameter int Q       = KYBER_Q
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_empty,
    output logic               gimme,
    output logic [COEFF_W-1:0] coeff,
    output logic               coeff_valid,
    output logic [7:0]         coeff_idx,
    output logic               done,
    output logic               busy
`ifdef KECCAK_PARSE_STATS_EN
    ,
    output logic [15:0]        rej_cnt,
    output logic [7:0]         word_cnt
`endif
);

    localparam logic [7:0] LAST_IDX = 8'(N_COEFF - 1);

    parse_state_t       state;
    logic               discard;
    logic [7:0]         count;
    logic [COEFF_W-1:0] cand;
    logic               have12;
    logic [6:0]         bcnt;
    logic               accept;
    logic               push;
    logic               pop12;
    logic               pop_now;
    logic               disc_on_start;
    logic               last_cand;

    assign accept  = cand_ok(cand, Q);
    assign push    = (state == ST_WAIT) && in_valid && !start;
    assign pop12   = (state == ST_RUN) && have12 && !start;
    assign pop_now = (state == ST_REQ) && gimme && !in_empty;
    // A word is still owed to us after a restart if a pop is pending and not
    // answered this cycle, or if a pop is happening right now.
    assign disc_on_start = (((state == ST_WAIT) || discard) && !in_valid) || pop_now;
    // After this candidate fewer than 12 bits remain, so a refill is needed.
    assign last_cand = (bcnt < 7'(2 * COEFF_W));

    parse_bitbuf #(
        .WORD_W (WORD_W)
    ) u_bitbuf (
        .clk    (clk),
        .rst    (rst),
        .clear  (start),
        .push   (push),
        .pop12  (pop12),
        .data   (in_data),
        .cand   (cand),
        .have12 (have12),
        .bcnt   (bcnt)
    );

    // Parse FSM: word request handshake, candidate acceptance and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            gimme       <= 1'b0;
            coeff       <= '0;
            coeff_valid <= 1'b0;
            coeff_idx   <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            discard     <= 1'b0;
            count       <= '0;
        end else begin
            coeff_valid <= 1'b0;
            done        <= 1'b0;
            if (done) begin
                busy <= 1'b0;
            end
            if (start) begin
                state     <= ST_REQ;
                busy      <= 1'b1;
                coeff_idx <= '0;
                count     <= '0;
                discard   <= disc_on_start;
                gimme     <= !disc_on_start;
            end else begin
                case (state)
                    ST_IDLE: begin
                        gimme <= 1'b0;
                    end
                    ST_REQ: begin
                        if (discard) begin
                            if (in_valid) begin
                                discard <= 1'b0;
                                gimme   <= 1'b1;
                            end
                        end else if (gimme && !in_empty) begin
                            state <= ST_WAIT;
                            gimme <= 1'b0;
                        end else begin
                            gimme <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (in_valid) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (have12) begin
                            if (accept) begin
                                coeff       <= cand;
                                coeff_idx   <= count;
                                coeff_valid <= 1'b1;
                                count       <= count + 8'd1;
                            end
                            if (accept && (count == LAST_IDX)) begin
                                done  <= 1'b1;
                                state <= ST_IDLE;
                            end else if (last_cand) begin
                                state <= ST_REQ;
                                gimme <= 1'b1;
                            end
                        end else begin
                            state <= ST_REQ;
                            gimme <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        gimme <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef KECCAK_PARSE_STATS_EN
    // Statistics: saturating reject count and count of every word taken from keccak.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            rej_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            if (pop12 && !accept && (rej_cnt != 16'hFFFF)) begin
                rej_cnt <= rej_cnt + 16'd1;
            end
            if (in_valid && ((state == ST_WAIT) || discard)) begin
                word_cnt <= word_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_keccak_parse.sv
// Bench for keccak_parse: a keccak output-FIFO model feeds words, a monitor
// collects coefficients, and a byte-level Kyber parse model predicts them.
module tb_keccak_parse;

    logic        clk, rst, start, in_valid, in_empty;
    logic [63:0] in_data;
    logic        gimme, coeff_valid, done, busy;
    logic [11:0] coeff;
    logic [7:0]  coeff_idx;
`ifdef KECCAK_PARSE_STATS_EN
    logic [15:0] rej_cnt;
    logic [7:0]  word_cnt;
`endif

    keccak_parse dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_empty(in_empty), .gimme(gimme), .coeff(coeff), .coeff_valid(coeff_valid),
        .coeff_idx(coeff_idx), .done(done), .busy(busy)
`ifdef KECCAK_PARSE_STATS_EN
        , .rej_cnt(rej_cnt), .word_cnt(word_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // keccak FIFO model state
    logic [63:0] src[$];
    logic [63:0] pend_data;
    int pend_cnt = 0, pops = 0, delivered = 0, proto_err = 0;
    int fixed_lat = 0, first_iv_cyc = -1, pop_cyc = -1;
    bit rand_empty = 0;

    // monitor state
    logic [11:0] got_c[$];
    logic [7:0]  got_i[$];
    int first_cv_cyc = -1, done_cnt = 0;
    logic [7:0] done_idx;
    bit done_cv, busy_at_done, busy_after_done, chk_after;

    // reference model output
    logic [11:0] exp_c[$];
    int exp_words;

    initial begin
        in_valid = 1'b0; in_empty = 1'b1; in_data = '0;
        forever begin
            @(negedge clk);
            in_valid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    in_valid = 1'b1; in_data = pend_data; delivered++;
                    if (first_iv_cyc < 0) first_iv_cyc = cyc;
                end
            end
            in_empty = !(src.size() > 0 && !(rand_empty && $urandom_range(0, 3) == 0));
            if (gimme && !in_empty) begin
                if (pend_cnt > 0) proto_err++;
                pend_data = src.pop_front();
                pend_cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
                pops++; pop_cyc = cyc;
            end
        end
    end

    initial begin
        chk_after = 0;
        forever begin
            @(negedge clk);
            if (coeff_valid === 1'b1) begin
                got_c.push_back(coeff); got_i.push_back(coeff_idx);
                if (first_cv_cyc < 0) first_cv_cyc = cyc;
            end
            if (chk_after) begin busy_after_done = busy; chk_after = 0; end
            if (done === 1'b1) begin
                done_cnt++; done_idx = coeff_idx; done_cv = coeff_valid; busy_at_done = busy; chk_after = 1;
            end
        end
    end

    // Kyber parse on the byte stream: d1 = b0 + 256*(b1 mod 16), d2 = (b1>>4) + 16*b2.
    task automatic build_exp(input logic [63:0] w[$]);
        logic [7:0] by[$];
        int last_j, d1, d2;
        exp_c.delete(); last_j = 0;
        foreach (w[i]) for (int b = 0; b < 8; b++) by.push_back(w[i][8*b +: 8]);
        for (int k = 0; 3*k+2 < by.size() && exp_c.size() < 256; k++) begin
            d1 = int'(by[3*k]) + 256 * (int'(by[3*k+1]) % 16);
            d2 = int'(by[3*k+1]) / 16 + 16 * int'(by[3*k+2]);
            if (d1 < 3329) begin exp_c.push_back(12'(d1)); last_j = 2*k; end
            if (exp_c.size() < 256 && d2 < 3329) begin exp_c.push_back(12'(d2)); last_j = 2*k+1; end
        end
        exp_words = (12 * (last_j + 1) + 63) / 64;
    endtask

    function automatic int first_diff();
        int n = (got_c.size() < exp_c.size()) ? got_c.size() : exp_c.size();
        for (int i = 0; i < n; i++)
            if (got_c[i] !== exp_c[i] || got_i[i] !== 8'(i)) return i;
        if (got_c.size() != exp_c.size()) return n;
        return -1;
    endfunction

    task automatic idle();
        src.delete(); fixed_lat = 0; rand_empty = 0;
        repeat (8) @(negedge clk);
    endtask

    task automatic arm();
        got_c.delete(); got_i.delete();
        first_cv_cyc = -1; first_iv_cyc = -1; done_cnt = 0;
        pops = 0; delivered = 0; proto_err = 0;
    endtask

    task automatic run_poly(input logic [63:0] w[$], input int maxc, output bit to);
        src = w; arm();
        start = 1'b1; @(negedge clk); start = 1'b0;
        to = 1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done_cnt > 0) begin to = 0; break; end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (gimme !== 1'b0) begin errors++; $display("FAIL reset_gimme: got %b want 0", gimme); end
        checks++; if (coeff !== 12'd0) begin errors++; $display("FAIL reset_coeff: got %0h want 0", coeff); end
        checks++; if (coeff_valid !== 1'b0) begin errors++; $display("FAIL reset_coeff_valid: got %b want 0", coeff_valid); end
        checks++; if (coeff_idx !== 8'd0) begin errors++; $display("FAIL reset_coeff_idx: got %0d want 0", coeff_idx); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef KECCAK_PARSE_STATS_EN
        checks++; if (rej_cnt !== 16'd0) begin errors++; $display("FAIL reset_rej_cnt: got %0d want 0", rej_cnt); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [63:0] w[$];
        bit to; int fd;
        idle();
        w.push_back(64'h0000_0000_0000_0D01);
        repeat (60) w.push_back(64'd0);
        build_exp(w); run_poly(w, 5000, to);
        fd = first_diff();
        checks++; if (to) begin errors++; $display("FAIL single_timeout: done not seen, got %0d coeffs want 256", got_c.size()); end
        checks++; if (got_c[0] !== 12'd0 || got_i[0] !== 8'd0) begin errors++; $display("FAIL single_first: got coeff %0h idx %0d want 0 idx 0", got_c[0], got_i[0]); end
        checks++; if (first_cv_cyc - first_iv_cyc != 3) begin errors++; $display("FAIL single_latency: got %0d want 3", first_cv_cyc - first_iv_cyc); end
        checks++; if (fd != -1) begin errors++; $display("FAIL single_seq: first difference at %0d want none", fd); end
    endtask

    task automatic test_boundary();
        logic [63:0] w[$];
        logic [63:0] t;
        bit to; int fd;
        idle();
        t = {$urandom, $urandom}; t[11:0] = 12'hD00;
        w.push_back(t);
        repeat (70) w.push_back({$urandom, $urandom});
        build_exp(w); run_poly(w, 5000, to);
        fd = first_diff();
        checks++; if (got_c[0] !== 12'd3328 || got_i[0] !== 8'd0) begin errors++; $display("FAIL boundary_accept: got coeff %0d idx %0d want 3328 idx 0", got_c[0], got_i[0]); end
        checks++; if (first_cv_cyc - first_iv_cyc != 2) begin errors++; $display("FAIL boundary_latency: got %0d want 2", first_cv_cyc - first_iv_cyc); end
        checks++; if (to || fd != -1) begin errors++; $display("FAIL boundary_seq: timeout %0d first difference %0d want 0 / none", to, fd); end
        checks++; if (pops != exp_words) begin errors++; $display("FAIL boundary_pops: got %0d want %0d", pops, exp_words); end
    endtask

    task automatic test_stitch();
        logic [63:0] w[$];
        logic [63:0] t;
        bit to; int fd;
        idle();
        w.push_back(64'hA000_0000_0000_0000);
        t = {$urandom, $urandom}; t[7:0] = 8'h12;
        w.push_back(t);
        repeat (70) w.push_back({$urandom, $urandom});
        build_exp(w); run_poly(w, 5000, to);
        fd = first_diff();
        checks++; if (got_c[5] !== 12'h12A || got_i[5] !== 8'd5) begin errors++; $display("FAIL stitch_cand: got %0h idx %0d want 12a idx 5", got_c[5], got_i[5]); end
        checks++; if (to || fd != -1) begin errors++; $display("FAIL stitch_seq: timeout %0d first difference %0d want 0 / none", to, fd); end
    endtask

    task automatic test_all_zero();
        logic [63:0] w[$];
        bit to; int fd;
        idle();
        rand_empty = 1;
        repeat (60) w.push_back(64'd0);
        build_exp(w); run_poly(w, 8000, to);
        fd = first_diff();
        checks++; if (to) begin errors++; $display("FAIL zero_timeout: got %0d coeffs want 256", got_c.size()); end
        checks++; if (pops != 48) begin errors++; $display("FAIL zero_pops: got %0d want 48", pops); end
        checks++; if (got_c.size() != 256 || fd != -1) begin errors++; $display("FAIL zero_seq: got %0d coeffs, first difference %0d", got_c.size(), fd); end
        checks++; if (done_cnt != 1 || done_idx !== 8'd255 || done_cv !== 1'b1) begin errors++; $display("FAIL zero_done: got count %0d idx %0d valid %b want 1 255 1", done_cnt, done_idx, done_cv); end
        checks++; if (busy_at_done !== 1'b1 || busy_after_done !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b then %b want 1 then 0", busy_at_done, busy_after_done); end
        checks++; if (proto_err != 0) begin errors++; $display("FAIL zero_proto: got %0d extra pops want 0", proto_err); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            logic [63:0] w[$];
            bit to; int fd;
            idle();
            rand_empty = 1;
            repeat (90) w.push_back({$urandom, $urandom});
            build_exp(w); run_poly(w, 8000, to);
            fd = first_diff();
            checks++; if (to || fd != -1) begin errors++; $display("FAIL random_seq: run %0d timeout %0d first difference %0d", r, to, fd); end
            checks++; if (pops != exp_words) begin errors++; $display("FAIL random_pops: run %0d got %0d want %0d", r, pops, exp_words); end
            checks++; if (done_idx !== 8'd255 || proto_err != 0) begin errors++; $display("FAIL random_done: run %0d idx %0d proto %0d want 255 0", r, done_idx, proto_err); end
        end
    endtask

    task automatic test_all_ones();
        logic [63:0] w[$];
        bit to;
        idle();
        repeat (20) w.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        run_poly(w, 400, to);
        checks++; if (got_c.size() != 0 || done_cnt != 0) begin errors++; $display("FAIL ones_none: got %0d coeffs %0d done want 0 0", got_c.size(), done_cnt); end
        checks++; if (pops != 20 || delivered != 20) begin errors++; $display("FAIL ones_pops: got %0d pops %0d words want 20", pops, delivered); end
        checks++; if (gimme !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ones_req: got gimme %b busy %b want 1 1", gimme, busy); end
`ifdef KECCAK_PARSE_STATS_EN
        checks++; if (rej_cnt !== 16'((64 * delivered) / 12)) begin errors++; $display("FAIL ones_rej_cnt: got %0d want %0d", rej_cnt, (64 * delivered) / 12); end
        checks++; if (word_cnt !== 8'(delivered)) begin errors++; $display("FAIL ones_word_cnt: got %0d want %0d", word_cnt, delivered); end
`endif
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        checks++; if (busy !== 1'b0 || gimme !== 1'b0) begin errors++; $display("FAIL ones_reset: got busy %b gimme %b want 0 0", busy, gimme); end
    endtask

    task automatic test_restart();
        logic [63:0] w[$];
        bit to; int fd;
        idle();
        fixed_lat = 3;
        w.push_back(64'h0000_0000_0000_0123);
        repeat (60) w.push_back(64'd0);
        build_exp(w[1:$]);
        src = w; arm();
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int i = 0; i < 50 && pops < 1; i++) @(negedge clk);
        checks++; if (pops < 1) begin errors++; $display("FAIL restart_pop: got %0d pops want 1", pops); end
        while (pops >= 1 && cyc < pop_cyc + 1) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        to = 1;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (done_cnt > 0) begin to = 0; break; end
        end
        fd = first_diff();
        checks++; if (to || fd != -1) begin errors++; $display("FAIL restart_seq: timeout %0d first difference %0d", to, fd); end
        checks++; if (got_i[0] !== 8'd0) begin errors++; $display("FAIL restart_idx: got %0d want 0", got_i[0]); end
        checks++; if (proto_err != 0 || pops != 49) begin errors++; $display("FAIL restart_pops: got %0d pops %0d overlaps want 49 0", pops, proto_err); end
    endtask

    task automatic test_rst_midrun();
        logic [63:0] w[$];
        int n;
        idle();
        repeat (90) w.push_back({$urandom, $urandom});
        src = w; arm();
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int i = 0; i < 2000 && got_c.size() < 10; i++) @(negedge clk);
        rst = 1'b1; @(negedge clk);
        checks++; if (gimme !== 1'b0 || coeff_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_ctrl: got gimme %b valid %b done %b busy %b want 0", gimme, coeff_valid, done, busy); end
        checks++; if (coeff !== 12'd0 || coeff_idx !== 8'd0) begin errors++; $display("FAIL rst_data: got coeff %0h idx %0d want 0 0", coeff, coeff_idx); end
`ifdef KECCAK_PARSE_STATS_EN
        checks++; if (rej_cnt !== 16'd0 || word_cnt !== 8'd0) begin errors++; $display("FAIL rst_stats: got %0d %0d want 0 0", rej_cnt, word_cnt); end
`endif
        rst = 1'b0;
        n = got_c.size();
        repeat (20) @(negedge clk);
        checks++; if (got_c.size() != n || done_cnt != 0) begin errors++; $display("FAIL rst_quiet: got %0d new coeffs %0d done want 0 0", got_c.size() - n, done_cnt); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        test_reset();
        test_single_word();
        test_boundary();
        test_stitch();
        test_all_zero();
        test_random();
        test_all_ones();
        test_restart();
        test_rst_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
